// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction-fetch stage.
// State encoding and the fetch packet carried from memory to decode.
package fetch_pkg;

    localparam logic [2:0] FS_IDLE = 3'd0;
    localparam logic [2:0] FS_REQ  = 3'd1;
    localparam logic [2:0] FS_WAIT = 3'd2;
    localparam logic [2:0] FS_KILL = 3'd3;
    localparam logic [2:0] FS_HOLD = 3'd4;

    localparam int PKT_W = 96;

    typedef enum logic [2:0] {
        ST_IDLE = FS_IDLE,
        ST_REQ  = FS_REQ,
        ST_WAIT = FS_WAIT,
        ST_KILL = FS_KILL,
        ST_HOLD = FS_HOLD
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc4;
    } fetch_pkt_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry buffer for a fetch packet that arrived while
// the decode slot was occupied and stalled.
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic             rd,
    input  logic             clr,
    input  logic [PKT_W-1:0] din,
    output logic             valid,
    output logic [PKT_W-1:0] dout
);

    // Flush wins over a write; a read empties the entry.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (wr) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (rd) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: fetch stage between the PC register and decode.
// Single-outstanding imem handshake, registered output slot, one-entry skid.
module inst_fetch
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic [31:0] pc_plus4_i,
    input  logic        ce_i,
    input  logic        branch_flag_i,
    input  logic        id_stall_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        fetch_stall_o,
    output logic        id_valid_o,
    output logic [31:0] id_inst_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_pc_plus4_o
);

    fetch_state_t     state;
    fetch_state_t     state_nxt;
    logic [31:0]      req_pc;
    logic [31:0]      req_pc4;
    logic             in_wait;
    logic             accept;
    logic             slot_free;
    logic             skid_wr;
    logic             skid_rd;
    logic             skid_valid;
    logic [PKT_W-1:0] skid_dout;
    fetch_pkt_t       resp_pkt;
    fetch_pkt_t       skid_pkt;

    assign in_wait   = (state == ST_WAIT);
    assign accept    = in_wait && imem_rvalid_i && !branch_flag_i;
    assign slot_free = !id_valid_o || !id_stall_i;
    assign skid_wr   = accept && !slot_free;
    assign skid_rd   = (state == ST_HOLD) && !id_stall_i && !branch_flag_i;
    assign resp_pkt  = '{inst: imem_rdata_i, pc: req_pc, pc4: req_pc4};
    assign skid_pkt  = fetch_pkt_t'(skid_dout);

    assign imem_req_o  = (state == ST_REQ);
    assign imem_addr_o = imem_req_o ? pc_i : 32'd0;

    // The PC advances only on an accepted response or a branch redirect.
    assign fetch_stall_o = !rst && !branch_flag_i
                           && !(in_wait && imem_rvalid_i);

    fetch_skid_buf u_skid (
        .clk   (clk),
        .rst   (rst),
        .wr    (skid_wr),
        .rd    (skid_rd),
        .clr   (branch_flag_i),
        .din   (resp_pkt),
        .valid (skid_valid),
        .dout  (skid_dout)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic for the request/response handshake.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (ce_i) state_nxt = ST_REQ;
            end
            ST_REQ: begin
                if (imem_gnt_i) begin
                    state_nxt = branch_flag_i ? ST_KILL : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid_i) begin
                    if (branch_flag_i || slot_free) state_nxt = ST_REQ;
                    else                            state_nxt = ST_HOLD;
                end else if (branch_flag_i) begin
                    state_nxt = ST_KILL;
                end
            end
            ST_KILL: begin
                if (imem_rvalid_i) state_nxt = ST_REQ;
            end
            ST_HOLD: begin
                if (branch_flag_i || !id_stall_i) state_nxt = ST_REQ;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Capture the PC pair of the request memory has just accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_pc  <= 32'd0;
            req_pc4 <= 32'd0;
        end else if (imem_req_o && imem_gnt_i) begin
            req_pc  <= pc_i;
            req_pc4 <= pc_plus4_i;
        end
    end

    // Output slot: flush on branch, drain skid first, else take a response.
    always_ff @(posedge clk) begin
        if (rst || branch_flag_i) begin
            id_valid_o    <= 1'b0;
            id_inst_o     <= 32'd0;
            id_pc_o       <= 32'd0;
            id_pc_plus4_o <= 32'd0;
        end else if (!id_stall_i) begin
            if (skid_valid) begin
                id_valid_o    <= 1'b1;
                id_inst_o     <= skid_pkt.inst;
                id_pc_o       <= skid_pkt.pc;
                id_pc_plus4_o <= skid_pkt.pc4;
            end else if (accept) begin
                id_valid_o    <= 1'b1;
                id_inst_o     <= resp_pkt.inst;
                id_pc_o       <= resp_pkt.pc;
                id_pc_plus4_o <= resp_pkt.pc4;
            end else begin
                id_valid_o    <= 1'b0;
            end
        end else if (accept && !id_valid_o) begin
            id_valid_o    <= 1'b1;
            id_inst_o     <= resp_pkt.inst;
            id_pc_o       <= resp_pkt.pc;
            id_pc_plus4_o <= resp_pkt.pc4;
        end
    end

endmodule
